// File: rtl/i2c_xfer_seq_pkg.sv
// Shared widths, FSM state encoding and helpers for the I2C transfer sequencer.
package i2c_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_BYTE_W = 8;
   localparam int I2C_LEN_W  = 8;

   typedef enum logic [2:0] {
      IDLE,
      PREFILL,
      START,
      RUN,
      DONE
   } xfer_state_e;

   // Byte counters never wrap below zero.
   function automatic logic [I2C_LEN_W-1:0] satDec(input logic [I2C_LEN_W-1:0] v);
      return (v == '0) ? v : v - I2C_LEN_W'(1);
   endfunction

endpackage

// File: rtl/i2c_xfer_seq_if.sv
// Command, byte-stream and controller signals of the I2C transfer sequencer.
interface i2c_xfer_seq_if #(parameter int DEPTH = 16);
   import i2c_pkg::*;

   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_rw;
   logic [I2C_ADDR_W-1:0] cmd_addr;
   logic [I2C_LEN_W-1:0]  cmd_len;

   logic                  wdat_valid;
   logic                  wdat_ready;
   logic [I2C_BYTE_W-1:0] wdat;

   logic                  rdat_valid;
   logic                  rdat_ready;
   logic [I2C_BYTE_W-1:0] rdat;

   logic                  ctrl_start;
   logic                  ctrl_wr_ctrl;
   logic [I2C_ADDR_W-1:0] ctrl_slave_addr;
   logic [I2C_LEN_W-1:0]  ctrl_data_bytes;
   logic [I2C_BYTE_W-1:0] ctrl_w_data;
   logic                  ctrl_busy;
   logic                  ctrl_byte_done;
   logic [I2C_BYTE_W-1:0] ctrl_r_data;

   logic                  done;
   logic                  err;
   logic [LVL_W-1:0]      wfifo_level;

   // The sequencer itself.
   modport master (
      input  cmd_valid, cmd_rw, cmd_addr, cmd_len,
      input  wdat_valid, wdat, rdat_ready,
      input  ctrl_busy, ctrl_byte_done, ctrl_r_data,
      output cmd_ready, wdat_ready, rdat_valid, rdat,
      output ctrl_start, ctrl_wr_ctrl, ctrl_slave_addr, ctrl_data_bytes, ctrl_w_data,
      output done, err, wfifo_level
   );

   // The surrounding system: command source, byte producer/consumer and controller.
   modport slave (
      output cmd_valid, cmd_rw, cmd_addr, cmd_len,
      output wdat_valid, wdat, rdat_ready,
      output ctrl_busy, ctrl_byte_done, ctrl_r_data,
      input  cmd_ready, wdat_ready, rdat_valid, rdat,
      input  ctrl_start, ctrl_wr_ctrl, ctrl_slave_addr, ctrl_data_bytes, ctrl_w_data,
      input  done, err, wfifo_level
   );

endinterface

// File: rtl/i2c_byte_fifo.sv
// Synchronous show-ahead byte FIFO; a push at full is taken only alongside a pop.
module i2c_byte_fifo
   import i2c_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push_i,
   input  logic [I2C_BYTE_W-1:0]     data_i,
   input  logic                      pop_i,
   output logic [I2C_BYTE_W-1:0]     data_o,
   output logic [$clog2(DEPTH):0]    level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [I2C_BYTE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wptr_q;
   logic [AW-1:0]         rptr_q;
   logic [AW:0]           level_q;
   logic                  doPush;
   logic                  doPop;

   always_comb begin
      doPop  = pop_i && (level_q != '0);
      doPush = push_i && ((level_q != (AW+1)'(DEPTH)) || doPop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (doPush) wptr_q <= wptr_q + AW'(1);
         if (doPop)  rptr_q <= rptr_q + AW'(1);
         case ({doPush, doPop})
            2'b10:   level_q <= level_q + (AW+1)'(1);
            2'b01:   level_q <= level_q - (AW+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && doPush) mem_q[wptr_q] <= data_i;
   end

   assign data_o  = mem_q[rptr_q];
   assign level_o = level_q;

endmodule

// File: rtl/i2c_xfer_seq.sv
// Sequences one I2C transfer per command, feeding write bytes from a FIFO to the controller.
// Define I2C_RD_FIFO_EN to buffer read bytes in a FIFO instead of single-cycle pulses.
module i2c_xfer_seq
   import i2c_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input logic            clk,
   input logic            rst_n,
   i2c_xfer_seq_if.master bus
);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   xfer_state_e           state_q, state_d;
   logic                  wrCtrl_q, wrCtrl_d;
   logic [I2C_ADDR_W-1:0] addr_q, addr_d;
   logic [I2C_LEN_W-1:0]  len_q, len_d;
   logic [I2C_LEN_W-1:0]  remain_q, remain_d;
   logic                  underrun_q, underrun_d;
   logic                  err_q, err_d;
   logic                  startSent_q;
   logic                  busyPrev_q;

   logic                  byteDone;
   logic                  busyFall;
   logic                  wPop;
   logic [I2C_BYTE_W-1:0] wHead;
   logic [LVL_W-1:0]      wLevel;
   logic                  wEmpty;
   logic                  wFull;
   logic                  rdOverflow;

   assign byteDone = (state_q == RUN) && bus.ctrl_byte_done;
   assign busyFall = busyPrev_q && !bus.ctrl_busy;
   assign wPop     = byteDone && wrCtrl_q;
   assign wEmpty   = (wLevel == '0);
   assign wFull    = (wLevel == LVL_W'(DEPTH));

   i2c_byte_fifo #(.DEPTH(DEPTH)) u_wfifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (bus.wdat_valid),
      .data_i  (bus.wdat),
      .pop_i   (wPop),
      .data_o  (wHead),
      .level_o (wLevel)
   );

`ifdef I2C_RD_FIFO_EN
   logic                  rPush;
   logic [I2C_BYTE_W-1:0] rHead;
   logic [LVL_W-1:0]      rLevel;

   assign rPush      = byteDone && !wrCtrl_q;
   assign rdOverflow = rPush && (rLevel == LVL_W'(DEPTH)) && !bus.rdat_ready;

   i2c_byte_fifo #(.DEPTH(DEPTH)) u_rfifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (rPush),
      .data_i  (bus.ctrl_r_data),
      .pop_i   (bus.rdat_ready),
      .data_o  (rHead),
      .level_o (rLevel)
   );

   assign bus.rdat_valid = (rLevel != '0);
   assign bus.rdat       = rHead;
`else
   logic                  rdatValid_q;
   logic [I2C_BYTE_W-1:0] rdat_q;

   assign rdOverflow = 1'b0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdatValid_q <= 1'b0;
         rdat_q      <= '0;
      end else begin
         rdatValid_q <= byteDone && !wrCtrl_q;
         if (byteDone && !wrCtrl_q) rdat_q <= bus.ctrl_r_data;
      end
   end

   assign bus.rdat_valid = rdatValid_q;
   assign bus.rdat       = rdat_q;
`endif

   always_comb begin
      state_d    = state_q;
      wrCtrl_d   = wrCtrl_q;
      addr_d     = addr_q;
      len_d      = len_q;
      remain_d   = remain_q;
      underrun_d = underrun_q;
      err_d      = rdOverflow;
      if (bus.wdat_valid) underrun_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               if (bus.cmd_len == '0) begin
                  err_d = 1'b1;
               end else begin
                  wrCtrl_d = bus.cmd_rw;
                  addr_d   = bus.cmd_addr;
                  len_d    = bus.cmd_len;
                  remain_d = bus.cmd_len;
                  state_d  = bus.cmd_rw ? PREFILL : START;
               end
            end
         end
         PREFILL: begin
            if (!wEmpty) state_d = START;
         end
         START: begin
            if (bus.ctrl_busy) state_d = RUN;
         end
         RUN: begin
            if (byteDone) begin
               remain_d = satDec(remain_q);
               // Underrun: this pop leaves the FIFO empty yet more bytes are still owed.
               if (wrCtrl_q && (wLevel <= LVL_W'(1)) && !bus.wdat_valid &&
                   (remain_q > I2C_LEN_W'(1))) begin
                  err_d      = 1'b1;
                  underrun_d = 1'b1;
               end
            end
            if (busyFall) begin
               state_d = DONE;
               if (remain_d != '0) err_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wrCtrl_q    <= 1'b0;
         addr_q      <= '0;
         len_q       <= '0;
         remain_q    <= '0;
         underrun_q  <= 1'b0;
         err_q       <= 1'b0;
         startSent_q <= 1'b0;
         busyPrev_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wrCtrl_q    <= wrCtrl_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         remain_q    <= remain_d;
         underrun_q  <= underrun_d;
         err_q       <= err_d;
         startSent_q <= (state_q == START);
         busyPrev_q  <= bus.ctrl_busy;
      end
   end

   assign bus.cmd_ready       = (state_q == IDLE);
   assign bus.ctrl_start      = (state_q == START) && !startSent_q;
   assign bus.ctrl_wr_ctrl    = wrCtrl_q;
   assign bus.ctrl_slave_addr = addr_q;
   assign bus.ctrl_data_bytes = len_q;
   assign bus.ctrl_w_data     = underrun_q ? 8'hFF : (wEmpty ? 8'h00 : wHead);
   assign bus.done            = (state_q == DONE);
   assign bus.err             = err_q;
   assign bus.wdat_ready      = !wFull;
   assign bus.wfifo_level     = wLevel;

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Directed scoreboard bench for i2c_xfer_seq: write, read, zero length, underrun, full FIFO, reset abort.
module tb_i2c_xfer_seq;
   import i2c_pkg::*;

   localparam int DEPTH = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int testCount = 0;
   int failCount = 0;
   int errSeen   = 0;
   int doneSeen  = 0;
   int readsSeen = 0;
   int starts;
   int e0, d0, rs0;

   logic [7:0] wq[$];
   logic [7:0] rq[$];

   always #5 clk = ~clk;

   i2c_xfer_seq_if #(.DEPTH(DEPTH)) bus();

   i2c_xfer_seq #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic rw, input logic [6:0] addr, input logic [7:0] len);
      bus.cmd_valid = 1'b1;
      bus.cmd_rw    = rw;
      bus.cmd_addr  = addr;
      bus.cmd_len   = len;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic pushByte(input logic [7:0] b);
      bus.wdat_valid = 1'b1;
      bus.wdat       = b;
      wq.push_back(b);
      @(negedge clk);
      bus.wdat_valid = 1'b0;
   endtask

   task automatic waitStart(output int n);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.ctrl_start === 1'b1) begin
            n++;
            bus.ctrl_busy = 1'b1;
         end
         @(negedge clk);
      end
   endtask

   task automatic byteDone(input logic [7:0] rdata, input bit isWrite);
      if (isWrite) checkOutput("ctrl_w_data", bus.ctrl_w_data, wq.pop_front());
      else rq.push_back(rdata);
      bus.ctrl_r_data    = rdata;
      bus.ctrl_byte_done = 1'b1;
      @(negedge clk);
      bus.ctrl_byte_done = 1'b0;
      @(negedge clk);
   endtask

   task automatic busyDrop;
      bus.ctrl_busy = 1'b0;
      @(negedge clk);
   endtask

   // Pulse counters and the read-byte scoreboard consumer.
   always @(negedge clk) begin
      if (bus.err === 1'b1) errSeen++;
      if (bus.done === 1'b1) doneSeen++;
      if (rst_n && bus.rdat_valid === 1'b1 && bus.rdat_ready) begin
         readsSeen++;
         if (rq.size() == 0) begin
            testCount++;
            failCount++;
            $error("[TB] FAIL rdat_extra: observed 0x%0h expected no byte", bus.rdat);
         end else begin
            checkOutput("rdat", bus.rdat, rq.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: observed no finish expected finish within 200us");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      bus.cmd_valid      = 1'b0;
      bus.cmd_rw         = 1'b0;
      bus.cmd_addr       = '0;
      bus.cmd_len        = '0;
      bus.wdat_valid     = 1'b0;
      bus.wdat           = '0;
      bus.rdat_ready     = 1'b1;
      bus.ctrl_busy      = 1'b0;
      bus.ctrl_byte_done = 1'b0;
      bus.ctrl_r_data    = '0;

      // Reset state
      cyc(3);
      rst_n = 1'b1;
      cyc(1);
      checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
      checkOutput("rst_level", bus.wfifo_level, 0);
      checkOutput("rst_wdat_ready", bus.wdat_ready, 1);
      checkOutput("rst_done", bus.done, 0);
      checkOutput("rst_err", bus.err, 0);
      checkOutput("rst_start", bus.ctrl_start, 0);
      checkOutput("rst_rdat_valid", bus.rdat_valid, 0);
      checkOutput("rst_len", bus.ctrl_data_bytes, 0);
      checkOutput("rst_w_data", bus.ctrl_w_data, 0);

      // Zero-length command
      e0 = errSeen;
      applyStimulus(1'b1, 7'h12, 8'd0);
      checkOutput("zl_err", bus.err, 1);
      checkOutput("zl_cmd_ready", bus.cmd_ready, 1);
      checkOutput("zl_start", bus.ctrl_start, 0);
      cyc(1);
      checkOutput("zl_err_clear", bus.err, 0);
      checkOutput("zl_cmd_ready2", bus.cmd_ready, 1);
      checkOutput("zl_start2", bus.ctrl_start, 0);
      checkOutput("zl_err_count", errSeen - e0, 1);

      // Prefilled write of four bytes
      for (int i = 0; i < 4; i++) pushByte(8'hF0 + 8'(i));
      checkOutput("wr_level", bus.wfifo_level, 4);
      e0 = errSeen;
      d0 = doneSeen;
      applyStimulus(1'b1, 7'h55, 8'd4);
      checkOutput("wr_cmd_ready", bus.cmd_ready, 0);
      checkOutput("wr_addr", bus.ctrl_slave_addr, 7'h55);
      checkOutput("wr_len", bus.ctrl_data_bytes, 4);
      checkOutput("wr_rw", bus.ctrl_wr_ctrl, 1);
      waitStart(starts);
      checkOutput("wr_starts", starts, 1);
      for (int i = 0; i < 4; i++) byteDone(8'h00, 1'b1);
      busyDrop();
      checkOutput("wr_done", bus.done, 1);
      checkOutput("wr_err", bus.err, 0);
      cyc(1);
      checkOutput("wr_done_clear", bus.done, 0);
      checkOutput("wr_idle", bus.cmd_ready, 1);
      checkOutput("wr_done_count", doneSeen - d0, 1);
      checkOutput("wr_err_count", errSeen - e0, 0);
      checkOutput("wr_level_end", bus.wfifo_level, 0);

      // Two-byte read
      e0  = errSeen;
      rs0 = readsSeen;
      applyStimulus(1'b0, 7'h21, 8'd2);
      checkOutput("rd_rw", bus.ctrl_wr_ctrl, 0);
      checkOutput("rd_cmd_ready", bus.cmd_ready, 0);
      waitStart(starts);
      checkOutput("rd_starts", starts, 1);
      byteDone(8'hA5, 1'b0);
      byteDone(8'h3C, 1'b0);
      busyDrop();
      checkOutput("rd_done", bus.done, 1);
      checkOutput("rd_err", bus.err, 0);
      cyc(2);
      checkOutput("rd_count", readsSeen - rs0, 2);
      checkOutput("rd_pending", rq.size(), 0);
      checkOutput("rd_err_count", errSeen - e0, 0);

      // Write underrun: three bytes requested, one supplied
      pushByte(8'h77);
      e0 = errSeen;
      applyStimulus(1'b1, 7'h30, 8'd3);
      waitStart(starts);
      checkOutput("ur_starts", starts, 1);
      byteDone(8'h00, 1'b1);
      checkOutput("ur_err_pulse", errSeen - e0, 1);
      checkOutput("ur_w_data", bus.ctrl_w_data, 8'hFF);
      busyDrop();
      checkOutput("ur_done", bus.done, 1);
      checkOutput("ur_err_at_done", bus.err, 1);
      cyc(1);
      checkOutput("ur_done_clear", bus.done, 0);
      checkOutput("ur_err_clear", bus.err, 0);
      checkOutput("ur_idle", bus.cmd_ready, 1);

      // Fill the write FIFO past capacity
      for (int i = 0; i <= DEPTH; i++) begin
         checkOutput("full_wdat_ready", bus.wdat_ready, (i < DEPTH) ? 1 : 0);
         bus.wdat_valid = 1'b1;
         bus.wdat       = 8'h10 + 8'(i);
         if (i < DEPTH) wq.push_back(8'h10 + 8'(i));
         @(negedge clk);
      end
      bus.wdat_valid = 1'b0;
      checkOutput("full_level", bus.wfifo_level, DEPTH);
      checkOutput("full_ready", bus.wdat_ready, 0);
      checkOutput("full_head", bus.ctrl_w_data, 8'h10);
      d0 = doneSeen;
      e0 = errSeen;
      applyStimulus(1'b1, 7'h40, 8'd2);
      waitStart(starts);
      checkOutput("full_starts", starts, 1);
      checkOutput("full_pop_data", bus.ctrl_w_data, wq.pop_front());
      bus.ctrl_byte_done = 1'b1;
      bus.wdat_valid     = 1'b1;
      bus.wdat           = 8'hEE;
      wq.push_back(8'hEE);
      @(negedge clk);
      bus.ctrl_byte_done = 1'b0;
      bus.wdat_valid     = 1'b0;
      checkOutput("full_pushpop_level", bus.wfifo_level, DEPTH);
      checkOutput("full_pushpop_ready", bus.wdat_ready, 0);
      @(negedge clk);
      byteDone(8'h00, 1'b1);
      checkOutput("full_after_pop", bus.wfifo_level, DEPTH - 1);
      busyDrop();
      checkOutput("full_done", bus.done, 1);
      checkOutput("full_err", bus.err, 0);
      cyc(1);
      checkOutput("full_err_count", errSeen - e0, 0);

      // Reset in the middle of a write
      applyStimulus(1'b1, 7'h50, 8'd5);
      waitStart(starts);
      checkOutput("ab_starts", starts, 1);
      e0 = errSeen;
      d0 = doneSeen;
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("ab_cmd_ready", bus.cmd_ready, 1);
      checkOutput("ab_level", bus.wfifo_level, 0);
      checkOutput("ab_done", bus.done, 0);
      checkOutput("ab_err", bus.err, 0);
      checkOutput("ab_start", bus.ctrl_start, 0);
      checkOutput("ab_len", bus.ctrl_data_bytes, 0);
      checkOutput("ab_w_data", bus.ctrl_w_data, 0);
      rst_n         = 1'b1;
      bus.ctrl_busy = 1'b0;
      wq.delete();
      cyc(4);
      checkOutput("ab_no_err", errSeen - e0, 0);
      checkOutput("ab_no_done", doneSeen - d0, 0);
      checkOutput("ab_idle", bus.cmd_ready, 1);
      checkOutput("ab_level_end", bus.wfifo_level, 0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/i2c_xfer_seq.md
I2C_XFER_SEQ -- requirements
Module: i2c_xfer_seq

Interface
REQ-001 Parameter DEPTH, default 16: write FIFO depth in bytes (and read FIFO depth when enabled); power of 2, minimum 4.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 cmd_valid  in  1  transfer request.
REQ-005 cmd_ready  out  1  request accepted when high with cmd_valid.
REQ-006 cmd_rw  in  1  1=write, 0=read.
REQ-007 cmd_addr  in  7  I2C slave address.
REQ-008 cmd_len  in  8  byte count, 1..255.
REQ-009 wdat_valid / wdat_ready / wdat  in/out/in  1/1/8  write-byte push port.
REQ-010 rdat_valid / rdat_ready / rdat  out/in/out  1/1/8  read-byte output.
REQ-011 ctrl_start  out  1  one-cycle start pulse to the I2C controller.
REQ-012 ctrl_wr_ctrl / ctrl_slave_addr / ctrl_data_bytes  out  1/7/8  latched cmd_rw/cmd_addr/cmd_len.
REQ-013 ctrl_w_data  out  8  current write byte.
REQ-014 ctrl_busy / ctrl_byte_done / ctrl_r_data  in/in/in  1/1/8  controller status and read data.
REQ-015 done  out  1  one-cycle pulse on transfer end.
REQ-016 err  out  1  one-cycle pulse on zero length, underrun or overflow.
REQ-017 wfifo_level  out  $clog2(DEPTH)+1  write FIFO occupancy.

Function
REQ-018 The FSM SHALL have the states IDLE, PREFILL, START, RUN and DONE.
REQ-019 IDLE:
- cmd_ready=1.
- Accept on cmd_valid&cmd_ready and latch cmd_rw/addr/len into ctrl_* and remaining=cmd_len.
- cmd_len==0: err pulse, stay IDLE.
REQ-020 PREFILL (write only): wait until wfifo_level>=1, then START; read goes IDLE->START directly.
REQ-021 START: assert ctrl_start for exactly one cycle, then wait for ctrl_busy=1 and enter RUN.
REQ-022 ctrl_w_data SHALL show the write FIFO head (show-ahead); a byte pushed in cycle N is visible at the head in N+1.
REQ-023 RUN, write, on ctrl_byte_done:
- Pop FIFO, decrement remaining.
- If the FIFO is empty while remaining>1: err pulse, ctrl_w_data=8'hFF until the next push.
REQ-024 RUN, read, on ctrl_byte_done: capture ctrl_r_data and decrement remaining.
REQ-025 RUN->DONE on ctrl_busy falling edge (1 then 0, registered).
- If remaining!=0 at that edge: err pulse in the same cycle as done.
REQ-026 DONE: done pulse for one cycle, then IDLE; cmd_ready=0 in all states except IDLE.
REQ-027 wdat_ready=!full (no same-cycle pop bypass); push and pop in the same cycle are both honoured and the level is unchanged.
REQ-028 The FIFO may be pushed in any state; leftover bytes after DONE remain for the next write.
REQ-029 The remaining counter SHALL saturate at 0 and never wrap.

Reset
REQ-030 rst_n=0 at a clock edge SHALL:
- Force IDLE.
- Empty both FIFOs.
- Clear remaining and all ctrl_* outputs, done, err and rdat_valid; wfifo_level=0.
- cmd_ready goes to 1 on the first cycle after release.
REQ-031 Reset mid-transfer SHALL abort with no done pulse and no err pulse.

Configuration
REQ-032 Macro I2C_RD_FIFO_EN defined: the read path is a DEPTH-entry FIFO with rdat_valid/rdat_ready handshake. A full FIFO drops the byte and pulses err.
REQ-033 Macro I2C_RD_FIFO_EN undefined:
- rdat_valid is a one-cycle pulse the cycle after each read ctrl_byte_done, with rdat=captured byte.
- rdat_ready is ignored; no overflow error.

Structure
REQ-034 Package i2c_pkg SHALL hold the FSM state enum, I2C_ADDR_W=7, I2C_BYTE_W=8 and I2C_LEN_W=8.
REQ-035 Sub-module i2c_byte_fifo (synchronous, show-ahead, parameter DEPTH) SHALL be instantiated for the write path and, under I2C_RD_FIFO_EN, for the read path.

Verification
REQ-036 Write, cmd_addr=7'h55, cmd_len=4, bytes F0..F3 prefilled, byte_done x4 -> ctrl_w_data sequence F0,F1,F2,F3; one ctrl_start; done once; no err.
REQ-037 Write, cmd_len=3, only 1 byte pushed -> err pulse on the first byte_done; ctrl_w_data=8'hFF; done still follows busy fall; err coincides with done.
REQ-038 Read, cmd_len=2, ctrl_r_data A5 then 3C -> rdat A5, 3C in order (both macro settings).
REQ-039 cmd_len=0 -> err one cycle, no ctrl_start, cmd_ready stays 1.
REQ-040 DEPTH+1 pushes with no transfer -> wdat_ready=0 at level DEPTH; push and pop in the same cycle at full keeps the level at DEPTH.
REQ-041 rst_n=0 during RUN -> next cycle IDLE, wfifo_level=0, no done, no err.
